wb_grf: RTL

- Consumer end of the M/W pipeline register. Takes the W-stage bundle: instruction, PC, PC+8, ALU result and DM read data.
- Decodes the write-back destination and selects the result to write.
- Contains the 32×32 general register file.
- Provides two D-stage read ports with W→D internal bypass, plus a write-back tap that the hazard/forwarding unit uses.

---
 rtl/wb_grf_pkg.sv | 33 +++
 rtl/wb_grf_dec.sv | 60 ++++++
 rtl/wb_grf.sv | 85 ++++++++
 3 files changed

// File: rtl/wb_grf_pkg.sv
//==============================================================================
// Module : wb_grf_pkg
// Brief  : Shared opcode/funct constants and write-data select for write-back.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package wb_grf_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        WD_ALU  = 2'd0,
        WD_DM   = 2'd1,
        WD_PC8  = 2'd2,
        WD_NONE = 2'd3
    } wd_sel_e;

endpackage

`default_nettype wire

// File: rtl/wb_grf_dec.sv
//==============================================================================
// Module : wb_dec
// Brief  : Combinational write-back decode: instruction -> {we, dest, wd_sel}.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module wb_dec
    import wb_grf_pkg::*;
(
    input  logic [31:0] ins,
    output logic        we,
    output logic [4:0]  dest,
    output wd_sel_e     wd_sel
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused_fields;

    assign w_op            = ins[31:26];
    assign w_funct         = ins[5:0];
    assign w_unused_fields = ^{ins[25:21], ins[10:6]};

    // we reports "this instruction writes"; the $0 filter is left to the user
    always_comb begin
        we     = 1'b0;
        dest   = 5'd0;
        wd_sel = WD_NONE;
        case (w_op)
            OP_RTYPE: begin
                if (w_funct == FN_ADD || w_funct == FN_SUB) begin
                    we     = 1'b1;
                    dest   = ins[15:11];
                    wd_sel = WD_ALU;
                end
            end
            OP_ORI, OP_LUI: begin
                we     = 1'b1;
                dest   = ins[20:16];
                wd_sel = WD_ALU;
            end
            OP_LW: begin
                we     = 1'b1;
                dest   = ins[20:16];
                wd_sel = WD_DM;
            end
            OP_JAL: begin
                we     = 1'b1;
                dest   = REG_RA;
                wd_sel = WD_PC8;
            end
            OP_SW, OP_BEQ: ;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_grf.sv
//==============================================================================
// Module : wb_grf
// Brief  : W-stage write-back select and 32x32 register file with W->D bypass.
//          Optional write trace under macro WB_GRF_TRACE_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module wb_grf
    import wb_grf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       INS_W,
    input  logic [DATA_W-1:0] PC_W,
    input  logic [DATA_W-1:0] PC8_W,
    input  logic [DATA_W-1:0] ALU_W,
    input  logic [DATA_W-1:0] DM_W,
    input  logic [REG_AW-1:0] A1,
    input  logic [REG_AW-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              WB_WE,
    output logic [REG_AW-1:0] WB_A,
    output logic [DATA_W-1:0] WB_D
);

    localparam int C_NREG = 1 << REG_AW;

    logic              w_we;
    logic [4:0]        w_dest;
    wd_sel_e           w_sel;
    logic [DATA_W-1:0] r_regs [0:C_NREG-1];

    wb_dec u_dec (
        .ins    (INS_W),
        .we     (w_we),
        .dest   (w_dest),
        .wd_sel (w_sel)
    );

    always_comb begin
        WB_D = '0;
        case (w_sel)
            WD_ALU:  WB_D = ALU_W;
            WD_DM:   WB_D = DM_W;
            WD_PC8:  WB_D = PC8_W;
            default: WB_D = '0;
        endcase
    end

    assign WB_A  = w_dest;
    assign WB_WE = w_we && (w_dest != 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < C_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (WB_WE) begin
            r_regs[WB_A] <= WB_D;
        end
    end

    // Bypass lets a D-stage read see the value being written this cycle
    assign RD1 = (A1 == '0) ? '0 : (WB_WE && A1 == WB_A) ? WB_D : r_regs[A1];
    assign RD2 = (A2 == '0) ? '0 : (WB_WE && A2 == WB_A) ? WB_D : r_regs[A2];

`ifdef WB_GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && WB_WE) begin
            $display("@%h: $%d <= %h", PC_W, WB_A, WB_D);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^PC_W;
`endif

endmodule

`default_nettype wire
